vector_deconstructor: RTL and testbench

//  Transmit side of the element stream that vector_constructor receives: latches a full

---
 rtl/vector_pkg.sv | 21 ++
 rtl/vector_deconstructor.sv | 105 ++++++++++
 tb/tb_vector_deconstructor.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/vector_pkg.sv
// Shared definitions for the vector element stream: the three-state
// controller encoding and default widths used by vector_constructor and
// vector_deconstructor.
package vector_pkg;

   localparam int DEF_ELEMENT_WIDTH    = 24;
   localparam int DEF_ADDR_WIDTH       = 3;
   localparam int DEF_VECTOR_DIMENSION = 3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      DONE = 2'd2
   } vec_state_t;

   // Element index width: enough bits to address every element, never zero.
   function automatic int idx_width(input int dim);
      return (dim > 1) ? $clog2(dim) : 1;
   endfunction

endpackage

// File: rtl/vector_deconstructor.sv
// Latches a complete vector from upstream, then streams its elements out one
// per downstream handshake with a running write address. Stops once the
// programmed number of elements has been emitted and holds done until reset.
module vector_deconstructor
   import vector_pkg::*;
#(
   parameter int ELEMENT_WIDTH    = DEF_ELEMENT_WIDTH,
   parameter int ADDR_WIDTH       = DEF_ADDR_WIDTH,
   parameter int VECTOR_DIMENSION = DEF_VECTOR_DIMENSION
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [ELEMENT_WIDTH-1:0] expected_elements,
   input  logic [ELEMENT_WIDTH-1:0] vector [0:VECTOR_DIMENSION-1],
   input  logic                     vector_valid,
   output logic                     vector_taken,
   output logic [ELEMENT_WIDTH-1:0] element_out,
   output logic                     element_ready,
   input  logic                     element_accept,
   output logic [ADDR_WIDTH-1:0]    addr,
   output logic                     done
);

   localparam int IDX_W = idx_width(VECTOR_DIMENSION);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VECTOR_DIMENSION - 1);

   vec_state_t               state;
   vec_state_t               state_nxt;
   logic [IDX_W-1:0]         idx;
   logic [ELEMENT_WIDTH-1:0] count;
   logic [ELEMENT_WIDTH-1:0] count_inc;
   logic [ELEMENT_WIDTH-1:0] expected_q;
   logic [ELEMENT_WIDTH-1:0] vec_buf [0:VECTOR_DIMENSION-1];
   logic                     take;
   logic                     fire;

   assign count_inc = count + ELEMENT_WIDTH'(1);

   // Next-state decode: decide when to latch a vector and when an element leaves.
   always_comb begin
      state_nxt = state;
      take      = 1'b0;
      fire      = 1'b0;
      case (state)
         IDLE: begin
            if (count == expected_q) begin
               state_nxt = DONE;
            end else if (vector_valid) begin
               take      = 1'b1;
               state_nxt = SEND;
            end
         end
         SEND: begin
            if (element_accept) begin
               fire = 1'b1;
               if (count_inc == expected_q) begin
                  state_nxt = DONE;
               end else if (idx == LAST_IDX) begin
                  state_nxt = IDLE;
               end
            end
         end
         DONE: begin
            state_nxt = DONE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // State, counters and vector buffer; reset clears everything including the buffer.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         idx        <= '0;
         count      <= '0;
         addr       <= '0;
         expected_q <= expected_elements;
         for (int i = 0; i < VECTOR_DIMENSION; i++) begin
            vec_buf[i] <= '0;
         end
      end else begin
         state <= state_nxt;
         if (take) begin
            vec_buf <= vector;
            idx     <= '0;
         end
         if (fire) begin
            addr  <= addr + ADDR_WIDTH'(1);
            count <= count_inc;
            idx   <= idx + IDX_W'(1);
         end
      end
   end

   // Output decode; the taken pulse is suppressed while reset is asserted.
   always_comb begin
      vector_taken  = take && !reset;
      element_ready = (state == SEND);
      element_out   = (state == SEND) ? vec_buf[idx] : '0;
      done          = (state == DONE);
   end

endmodule

// File: tb/tb_vector_deconstructor.sv
module tb_vector_deconstructor;

   logic        clk = 1'b0;
   logic        reset;
   logic [23:0] expected_elements;
   logic [23:0] vector [0:2];
   logic        vector_valid;
   logic        vector_taken;
   logic [23:0] element_out;
   logic        element_ready;
   logic        element_accept;
   logic [2:0]  addr;
   logic        done;

   typedef struct {
      logic [23:0] d;
      logic [2:0]  a;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad = 0;
   int   taken_cnt = 0;

   localparam logic [23:0] V0_0 = 24'h00AA00, V0_1 = 24'h01B480, V0_2 = 24'h005916;
   localparam logic [23:0] V1_0 = 24'h0015F0, V1_1 = 24'h45557E, V1_2 = 24'h020000;

   vector_deconstructor #(
      .ELEMENT_WIDTH(24), .ADDR_WIDTH(3), .VECTOR_DIMENSION(3)
   ) dut (
      .clk(clk), .reset(reset), .expected_elements(expected_elements),
      .vector(vector), .vector_valid(vector_valid), .vector_taken(vector_taken),
      .element_out(element_out), .element_ready(element_ready),
      .element_accept(element_accept), .addr(addr), .done(done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push(input logic [23:0] d, input logic [2:0] a);
      exp_t e;
      e.d = d;
      e.a = a;
      sb.push_back(e);
   endtask

   // Monitor: counts taken pulses and checks every accepted element against the scoreboard.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (vector_taken) taken_cnt++;
         if (element_ready && element_accept) begin
            if (sb.size() == 0) begin
               total++;
               bad++;
               $display("FAIL extra_element: got data %0h addr %0d, none expected", element_out, addr);
            end else begin
               e = sb.pop_front();
               chk("elem_data", element_out, e.d);
               chk("elem_addr", addr, e.a);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, required finish");
      $fatal(1, "watchdog");
   end

   task automatic do_reset(input int n, input logic [23:0] exp);
      reset = 1'b1;
      expected_elements = exp;
      vector_valid = 1'b0;
      element_accept = 1'b0;
      repeat (n) @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_taken"}, vector_taken, 0);
      chk({tag, "_ready"}, element_ready, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_addr"}, addr, 0);
      chk({tag, "_elem"}, element_out, 0);
   endtask

   task automatic offer(input logic [23:0] a, input logic [23:0] b, input logic [23:0] c);
      bit got = 0;
      vector[0] = a;
      vector[1] = b;
      vector[2] = c;
      vector_valid = 1'b1;
      for (int i = 0; i < 60 && !got; i++) begin
         @(negedge clk);
         if (vector_taken) got = 1;
      end
      if (!got) begin
         total++;
         bad++;
         $display("FAIL offer_timeout: vector_taken=0, required 1");
      end
      @(posedge clk);
      #1;
      vector_valid = 1'b0;
   endtask

   task automatic drain_and_check_done(input string tag);
      bit empty = 0;
      for (int i = 0; i < 100 && !empty; i++) begin
         @(posedge clk);
         #1;
         if (sb.size() == 0) empty = 1;
      end
      if (!empty) begin
         total++;
         bad++;
         $display("FAIL %s_drain: %0d elements outstanding, required 0", tag, sb.size());
         sb.delete();
      end
      chk({tag, "_done"}, done, 1);
   endtask

   initial begin
      int snap;
      reset = 1'b1;
      expected_elements = '0;
      vector_valid = 1'b0;
      element_accept = 1'b0;
      for (int i = 0; i < 3; i++) vector[i] = '0;

      // Reset state, then no vectors offered: done stays low.
      do_reset(5, 24'd6);
      chk_idle_outputs("rst");
      repeat (5) @(posedge clk);
      #1;
      chk("novec_done", done, 0);
      chk("novec_ready", element_ready, 0);

      // Two vectors, six elements, free-flowing accept.
      push(V0_0, 0); push(V0_1, 1); push(V0_2, 2);
      push(V1_0, 3); push(V1_1, 4); push(V1_2, 5);
      element_accept = 1'b1;
      snap = taken_cnt;
      offer(V0_0, V0_1, V0_2);
      offer(V1_0, V1_1, V1_2);
      drain_and_check_done("six");
      chk("six_taken", taken_cnt - snap, 2);
      vector_valid = 1'b1;
      snap = taken_cnt;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         chk("six_hold_done", done, 1);
         chk("six_hold_ready", element_ready, 0);
      end
      chk("six_done_ignores_valid", taken_cnt - snap, 0);
      vector_valid = 1'b0;

      // Backpressure on the second element.
      do_reset(2, 24'd6);
      push(V0_0, 0); push(V0_1, 1); push(V0_2, 2);
      push(V1_0, 3); push(V1_1, 4); push(V1_2, 5);
      offer(V0_0, V0_1, V0_2);
      element_accept = 1'b1;
      @(posedge clk);
      #1;
      element_accept = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         chk("bp_elem", element_out, V0_1);
         chk("bp_addr", addr, 1);
         chk("bp_ready", element_ready, 1);
      end
      element_accept = 1'b1;
      offer(V1_0, V1_1, V1_2);
      drain_and_check_done("bp");

      // Truncated final vector, and a third vector that is never acknowledged.
      do_reset(2, 24'd4);
      push(V0_0, 0); push(V0_1, 1); push(V0_2, 2); push(V1_0, 3);
      element_accept = 1'b1;
      offer(V0_0, V0_1, V0_2);
      offer(V1_0, V1_1, V1_2);
      drain_and_check_done("trunc");
      vector[0] = V0_0; vector[1] = V0_1; vector[2] = V0_2;
      vector_valid = 1'b1;
      snap = taken_cnt;
      repeat (10) @(posedge clk);
      #1;
      chk("trunc_third_taken", taken_cnt - snap, 0);
      vector_valid = 1'b0;

      // Zero elements: done one cycle after reset drops, no vector taken.
      do_reset(2, 24'd0);
      vector_valid = 1'b1;
      snap = taken_cnt;
      chk("zero_done_early", done, 0);
      @(posedge clk);
      #1;
      chk("zero_done", done, 1);
      repeat (3) @(posedge clk);
      #1;
      chk("zero_taken", taken_cnt - snap, 0);
      vector_valid = 1'b0;

      // Ten elements: address wraps 7 -> 0.
      do_reset(2, 24'd10);
      for (int i = 0; i < 10; i++) begin
         logic [23:0] d;
         d = (i % 3 == 0) ? V0_0 : (i % 3 == 1) ? V0_1 : V0_2;
         push(d, 3'(i));
      end
      element_accept = 1'b1;
      for (int k = 0; k < 4; k++) offer(V0_0, V0_1, V0_2);
      drain_and_check_done("wrap");

      // Reset in the middle of a vector, then replay from address 0.
      do_reset(2, 24'd6);
      push(V0_0, 0); push(V0_1, 1);
      element_accept = 1'b1;
      offer(V0_0, V0_1, V0_2);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      element_accept = 1'b0;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      chk_idle_outputs("midrst");
      chk("midrst_sb_empty", sb.size(), 0);
      push(V0_0, 0); push(V0_1, 1); push(V0_2, 2);
      push(V1_0, 3); push(V1_1, 4); push(V1_2, 5);
      element_accept = 1'b1;
      offer(V0_0, V0_1, V0_2);
      offer(V1_0, V1_1, V1_2);
      drain_and_check_done("replay");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
